// File: rtl/imem_pkg.sv
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared types and constants for the instruction-memory boot
//            controller: controller state encoding and the instruction words
//            the controller and its users need to recognise.
// Macro    : IMEM_CLEAR_EN adds the CLEAR state to imem_state_t.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_pkg;

  // Program terminator; fetching it halts the core.
  localparam logic [31:0] HALT_WORD_DEF = 32'hB4221820;

  // Canonical no-op encoding (add r0,r0,r0).
  localparam logic [31:0] NOP_WORD      = 32'h00000020;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
`ifdef IMEM_CLEAR_EN
    ,
    ST_CLEAR  = 2'd3
`endif
  } imem_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_sram.sv
// ============================================================================
// Module   : imem_sram
// Purpose  : DEPTH x 32 single-port instruction RAM. Synchronous write and
//            synchronous read; read data appears the cycle after an enabled
//            read and is held until the next one. No reset on the array or
//            on the read register.
// Ports    : clk             - clock
//            en, we          - access enable, write enable
//            addr [ADDR_W]   - word address
//            wdata/rdata[32] - write data / registered read data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_sram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        rdata <= r_mem[addr];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
// ============================================================================
// Module   : imem_boot_ctrl
// Purpose  : Owns the port of an imem_sram instance. Loads a program from a
//            valid/ready word stream, then serves IF-stage fetches with one
//            cycle latency, and halts when the terminator word is fetched.
//            The core is stalled whenever no program is running.
// Ports    : clk, reset (async, active low)
//            ld_valid/ld_data/ld_last/ld_ready - loader stream
//            reload                            - return to program load
//            fetch_req/fetch_addr              - IF request (byte address)
//            fetch_valid/fetch_inst            - IF response
//            cpu_stall, halted, prog_len       - core status
//            mem_en/mem_we/mem_addr/mem_wdata  - RAM strobes (to imem_sram)
//            mem_rdata                         - RAM read data (from imem_sram)
// Macro    : IMEM_CLEAR_EN - zero-fill the whole RAM before every load.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_ctrl
  import imem_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_inst,
  output logic              cpu_stall,
  output logic              halted,
  output logic [ADDR_W:0]   prog_len,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_len_max   = (ADDR_W + 1)'(DEPTH);
`ifdef IMEM_CLEAR_EN
  localparam imem_state_t       c_entry     = ST_CLEAR;
`else
  localparam imem_state_t       c_entry     = ST_LOAD;
`endif

  imem_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_prog_len;
  logic              r_ld_ready;
  logic              r_fetch_valid;
  logic              r_fetch_oob;
`ifdef IMEM_CLEAR_EN
  logic              r_clr_go;
  logic              w_clr_wr;
`endif

  logic        w_accept, w_reload_ok, w_fetch_go, w_addr_oob, w_halt_hit;
  logic [31:0] w_fetch_word;
  logic        w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^fetch_addr[1:0];

  // The RAM read register supplies the fetched word directly, so the word is
  // only known in the response cycle. The halt decision is therefore made
  // combinationally from it; the HALTED state register follows one edge later.
  assign w_fetch_word = r_fetch_oob ? HALT_WORD : mem_rdata;
  assign w_halt_hit   = r_fetch_valid && (w_fetch_word == HALT_WORD);
  assign w_addr_oob   = |fetch_addr[31:ADDR_W+2];
  assign w_accept     = (r_state == ST_LOAD) && ld_valid && r_ld_ready;
  assign w_reload_ok  = reload && ((r_state == ST_RUN) || (r_state == ST_HALTED));
  // Once the halt word is on the bus, any further request is already too late.
  assign w_fetch_go   = (r_state == ST_RUN) && fetch_req && !reload && !w_halt_hit;
`ifdef IMEM_CLEAR_EN
  // r_clr_go holds off the first fill write until reset has been released.
  assign w_clr_wr     = (r_state == ST_CLEAR) && r_clr_go;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_accept && (ld_last || (ld_data == HALT_WORD) || (r_wr_ptr == c_last_addr))) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_reload_ok) begin
          w_state_nxt = c_entry;
        end else if (w_halt_hit) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (w_reload_ok) begin
          w_state_nxt = c_entry;
        end
      end
`ifdef IMEM_CLEAR_EN
      ST_CLEAR: begin
        if (w_clr_wr && (r_wr_ptr == c_last_addr)) begin
          w_state_nxt = ST_LOAD;
        end
      end
`endif
      default: w_state_nxt = c_entry;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_accept) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = r_wr_ptr;
      mem_wdata = ld_data;
    end else if (w_fetch_go && !w_addr_oob) begin
      mem_en    = 1'b1;
      mem_addr  = fetch_addr[ADDR_W+1:2];
    end
`ifdef IMEM_CLEAR_EN
    else if (w_clr_wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = r_wr_ptr;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_entry;
      r_wr_ptr      <= '0;
      r_prog_len    <= '0;
      r_ld_ready    <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_oob   <= 1'b0;
`ifdef IMEM_CLEAR_EN
      r_clr_go      <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_ld_ready    <= (w_state_nxt == ST_LOAD);
      r_fetch_valid <= w_fetch_go;
      r_fetch_oob   <= w_fetch_go && w_addr_oob;
`ifdef IMEM_CLEAR_EN
      r_clr_go      <= (w_state_nxt == ST_CLEAR);
`endif
      if (w_reload_ok) begin
        r_wr_ptr   <= '0;
        r_prog_len <= '0;
      end else if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_prog_len != c_len_max) begin
          r_prog_len <= r_prog_len + 1'b1;
        end
      end
`ifdef IMEM_CLEAR_EN
      // The fill pointer wraps back to 0 after the last word, ready for LOAD.
      else if (w_clr_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
`endif
    end
  end

  assign ld_ready    = r_ld_ready;
  assign fetch_valid = r_fetch_valid;
  assign fetch_inst  = r_fetch_valid ? w_fetch_word : 32'h0;
  assign cpu_stall   = (r_state != ST_RUN) || w_halt_hit;
  assign halted      = (r_state == ST_HALTED) || w_halt_hit;
  assign prog_len    = r_prog_len;

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
// ============================================================================
// Module   : tb_imem_boot_ctrl
// Purpose  : Directed self-checking bench for imem_boot_ctrl with an
//            imem_sram instance on its RAM port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_ctrl;

  localparam logic [31:0] HALT = 32'hB4221820;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        reload = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        cpu_stall;
  logic        halted;
  logic [6:0]  prog_len;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] prog [4];

  imem_boot_ctrl #(.DEPTH(64), .ADDR_W(6), .HALT_WORD(HALT)) u_dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload(reload), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst),
    .cpu_stall(cpu_stall), .halted(halted), .prog_len(prog_len),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  imem_sram #(.DEPTH(64), .ADDR_W(6)) u_ram (
    .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr),
    .wdata(mem_wdata), .rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    for (int i = 0; i < 200 && !ld_ready; i++) step;
    check("ld_ready_up", 32'(ld_ready), 32'd1);
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step;
  endtask

  // {ld_ready, fetch_valid, cpu_stall, halted}
  function automatic logic [31:0] status();
    return 32'({ld_ready, fetch_valid, cpu_stall, halted});
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    prog[0] = 32'h8C080000;
    prog[1] = 32'h8C090020;
    prog[2] = 32'h8C0A0050;
    prog[3] = 32'h8C0B0008;

    // ---- reset state ----
    step; step;
    check("rst_status", status(), 32'b0010);
    check("rst_fetch_inst", fetch_inst, 32'h0);
    check("rst_prog_len", 32'(prog_len), 32'd0);
    check("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata[23:0]}, 32'h0);
    reset = 1'b1;
    wait_ready;
    check("load_status", status(), 32'b1010);

    // ---- 4 LW words then HALT without ld_last ----
    ld_valid = 1'b1; ld_data = prog[0]; ld_last = 1'b0;
    #1;
    check("ld_strobe", 32'({mem_en, mem_we, mem_addr}), 32'h00000100 >> 0 & 32'h0 | 32'b11_000000);
    check("ld_wdata", mem_wdata, prog[0]);
    for (int i = 0; i < 4; i++) load_word(prog[i], 1'b0);
    check("ld4_len", 32'(prog_len), 32'd4);
    check("ld4_stall", 32'(cpu_stall), 32'd1);
    load_word(HALT, 1'b0);
    ld_valid = 1'b0;
    check("ld5_len", 32'(prog_len), 32'd5);
    check("ld5_status", status(), 32'b0000);

    // ---- back-to-back fetches ----
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4));
      check("fetch_valid", 32'(fetch_valid), 32'd1);
      check("fetch_inst", fetch_inst, prog[i]);
    end
    fetch_req = 1'b0;
    step;
    check("fetch_idle", 32'(fetch_valid), 32'd0);
    fetch(32'd16);
    check("halt_inst", fetch_inst, HALT);
    check("halt_status", status(), 32'b0111);
    fetch(32'd20);
    check("halted_nofetch", status(), 32'b0011);
    fetch_req = 1'b0;

    // ---- reload from HALTED, full 64-word load ----
    reload = 1'b1;
    step;
    reload = 1'b0;
    check("reload_len", 32'(prog_len), 32'd0);
    check("reload_halted", 32'(halted), 32'd0);
    wait_ready;
    for (int i = 0; i < 64; i++) begin
      load_word(32'h10000000 + 32'(i), 1'b0);
      if (i == 62) begin
        check("ld63_len", 32'(prog_len), 32'd63);
        check("ld63_stall", 32'(cpu_stall), 32'd1);
      end
    end
    ld_valid = 1'b0;
    check("ld64_len", 32'(prog_len), 32'd64);
    check("ld64_status", status(), 32'b0000);
    fetch(32'd128);
    check("fetch128", fetch_inst, 32'h10000020);
    fetch(32'd252);
    check("fetch252", fetch_inst, 32'h1000003F);
    fetch(32'd256);
    check("oob_inst", fetch_inst, HALT);
    check("oob_status", status(), 32'b0111);
    fetch_req = 1'b0;
    step;
    check("oob_halted", status(), 32'b0011);

    // ---- short program with ld_last, then reload colliding with fetch ----
    reload = 1'b1;
    step;
    reload = 1'b0;
    wait_ready;
    load_word(32'h11111111, 1'b0);
    load_word(32'h22222222, 1'b1);
    ld_valid = 1'b0;
    check("last_len", 32'(prog_len), 32'd2);
    check("last_stall", 32'(cpu_stall), 32'd0);
    fetch(32'd4);
    check("fetch_w1", fetch_inst, 32'h22222222);
    reload = 1'b1;
    fetch(32'd0);
    reload = 1'b0;
    fetch_req = 1'b0;
    check("rl_fv", 32'(fetch_valid), 32'd0);
    check("rl_len", 32'(prog_len), 32'd0);
    check("rl_stall", 32'(cpu_stall), 32'd1);
    wait_ready;
    load_word(32'h33333333, 1'b1);
    ld_valid = 1'b0;
    fetch(32'd4);
    fetch_req = 1'b0;
    check("unloaded_fv", 32'(fetch_valid), 32'd1);
`ifdef IMEM_CLEAR_EN
    check("unloaded_word", fetch_inst, 32'h0);
`else
    check("unloaded_word", fetch_inst, 32'h22222222);
`endif

    // ---- asynchronous reset in the middle of a load ----
    reload = 1'b1;
    step;
    reload = 1'b0;
    wait_ready;
    load_word(32'hAAAA0000, 1'b0);
    load_word(32'hAAAA0001, 1'b0);
    check("mid_len", 32'(prog_len), 32'd2);
    ld_data = 32'hAAAA0002;
    #2;
    reset = 1'b0;
    #1;
    check("arst_status", status(), 32'b0010);
    check("arst_len", 32'(prog_len), 32'd0);
    check("arst_mem_en", 32'(mem_en), 32'd0);
    reset = 1'b1;
    ld_valid = 1'b0;
    step;
    wait_ready;
    load_word(32'h55550000, 1'b0);
    load_word(32'h55550001, 1'b1);
    ld_valid = 1'b0;
    check("reld_len", 32'(prog_len), 32'd2);
    fetch(32'd0);
    check("reld_w0", fetch_inst, 32'h55550000);
    fetch(32'd4);
    check("reld_w1", fetch_inst, 32'h55550001);
    fetch_req = 1'b0;
    step;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
